// File: rtl/display_reg_cmd_sequencer.sv
// Button-to-command sequencer for an N-bit up/down display register.
// Turns debounced button rises into single-cycle register commands with fixed
// priority, hold-to-auto-repeat on inc/dec and optional saturation at the limits.
module display_reg_cmd_sequencer #(
  parameter int unsigned N             = 4,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter bit          WRAP          = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         btn_clr,
  input  logic         btn_max,
  input  logic         btn_load,
  input  logic         btn_inc,
  input  logic         btn_dec,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] q,
  output logic         reg_reset_n,
  output logic         reg_set,
  output logic         reg_load,
  output logic         reg_add,
  output logic         reg_sub,
  output logic [N-1:0] reg_d,
  output logic         busy
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned NBTN    = 5;

  // Bit positions inside the packed button vector
  localparam int unsigned B_CLR  = 4;
  localparam int unsigned B_MAX  = 3;
  localparam int unsigned B_LOAD = 2;
  localparam int unsigned B_INC  = 1;
  localparam int unsigned B_DEC  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_CLR  = 3'd1,
    CMD_MAX  = 3'd2,
    CMD_LOAD = 3'd3,
    CMD_ADD  = 3'd4,
    CMD_SUB  = 3'd5
  } cmd_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              dir;        // 0 = incrementing, 1 = decrementing
  logic              dir_next;
  logic [NBTN-1:0]   btn;
  logic [NBTN-1:0]   btn_prev;
  logic [NBTN-1:0]   rise_c;
  logic              abort_c;
  logic              btn_dir_c;
  logic              expire_c;
  cmd_t              special_c;
  cmd_t              cmd_c;

  assign btn       = {btn_clr, btn_max, btn_load, btn_inc, btn_dec};
  assign rise_c    = btn & ~btn_prev;
  assign abort_c   = rise_c[B_CLR] | rise_c[B_MAX] | rise_c[B_LOAD];
  assign btn_dir_c = dir ? btn[B_DEC] : btn[B_INC];
  assign expire_c  = (cnt == CNT_W'(1));

  // Highest-priority non-repeating command among this cycle's rises
  always_comb begin
    special_c = CMD_NONE;
    if (rise_c[B_CLR])       special_c = CMD_CLR;
    else if (rise_c[B_MAX])  special_c = CMD_MAX;
    else if (rise_c[B_LOAD]) special_c = CMD_LOAD;
  end

  // Button history; reset high so a button held through reset never fires
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) btn_prev <= '1;
    else          btn_prev <= btn;
  end

  // State, repeat counter and remembered direction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      dir   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      dir   <= dir_next;
    end
  end

  // Next-state: arm on inc/dec rise, abort on clr/max/load, drop on release
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    dir_next   = dir;
    case (state)
      IDLE: begin
        if (!abort_c) begin
          if (rise_c[B_INC]) begin
            state_next = HOLD;
            cnt_next   = CNT_W'(HOLD_CYCLES);
            dir_next   = 1'b0;
          end else if (rise_c[B_DEC]) begin
            state_next = HOLD;
            cnt_next   = CNT_W'(HOLD_CYCLES);
            dir_next   = 1'b1;
          end
        end
      end
      HOLD, REPEAT: begin
        if (abort_c || !btn_dir_c) begin
          state_next = IDLE;
        end else if (expire_c) begin
          state_next = REPEAT;
          cnt_next   = CNT_W'(REPEAT_CYCLES);
        end else begin
          cnt_next   = cnt - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Command selection, then saturation against the register's current value
  always_comb begin
    cmd_c = CMD_NONE;
    case (state)
      IDLE: begin
        if (special_c != CMD_NONE) cmd_c = special_c;
        else if (rise_c[B_INC])    cmd_c = CMD_ADD;
        else if (rise_c[B_DEC])    cmd_c = CMD_SUB;
      end
      HOLD, REPEAT: begin
        if (special_c != CMD_NONE)     cmd_c = special_c;
        else if (btn_dir_c && expire_c) cmd_c = dir ? CMD_SUB : CMD_ADD;
      end
      default: cmd_c = CMD_NONE;
    endcase
    if (!WRAP) begin
      if ((cmd_c == CMD_ADD) && (&q))      cmd_c = CMD_NONE;
      else if ((cmd_c == CMD_SUB) && !(|q)) cmd_c = CMD_NONE;
    end
  end

  // Registered command pulses, captured load data and busy flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_reset_n <= 1'b0;
      reg_set     <= 1'b0;
      reg_load    <= 1'b0;
      reg_add     <= 1'b0;
      reg_sub     <= 1'b0;
      reg_d       <= '0;
      busy        <= 1'b0;
    end else begin
      reg_reset_n <= (cmd_c != CMD_CLR);
      reg_set     <= (cmd_c == CMD_MAX);
      reg_load    <= (cmd_c == CMD_LOAD);
      reg_add     <= (cmd_c == CMD_ADD);
      reg_sub     <= (cmd_c == CMD_SUB);
      if (cmd_c == CMD_LOAD) reg_d <= load_val;
      busy        <= (state_next != IDLE);
    end
  end

endmodule
